// File: rtl/ascon_pkg.sv
// Shared Ascon definitions: state packing, S-box table, round constants and rotate amounts.
package ascon_pkg;

  localparam int unsigned STATE_W = 320;
  localparam int unsigned LANE_W  = 64;
  localparam int unsigned NR_W    = 4;
  localparam int unsigned IDX_W   = 5;

  localparam int unsigned X0_MSB = 319;
  localparam int unsigned X0_LSB = 256;
  localparam int unsigned X1_MSB = 255;
  localparam int unsigned X1_LSB = 192;
  localparam int unsigned X2_MSB = 191;
  localparam int unsigned X2_LSB = 128;
  localparam int unsigned X3_MSB = 127;
  localparam int unsigned X3_LSB = 64;
  localparam int unsigned X4_MSB = 63;
  localparam int unsigned X4_LSB = 0;

  localparam int unsigned ROT_X0_A = 19;
  localparam int unsigned ROT_X0_B = 28;
  localparam int unsigned ROT_X1_A = 61;
  localparam int unsigned ROT_X1_B = 39;
  localparam int unsigned ROT_X2_A = 1;
  localparam int unsigned ROT_X2_B = 6;
  localparam int unsigned ROT_X3_A = 10;
  localparam int unsigned ROT_X3_B = 17;
  localparam int unsigned ROT_X4_A = 7;
  localparam int unsigned ROT_X4_B = 41;

  typedef struct packed {
    logic [LANE_W-1:0] x0;
    logic [LANE_W-1:0] x1;
    logic [LANE_W-1:0] x2;
    logic [LANE_W-1:0] x3;
    logic [LANE_W-1:0] x4;
  } ascon_state_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_t;

  // Column value {x0[i],..,x4[i]} with x0 as MSB
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic [4:0] sbox(input logic [4:0] v);
    return SBOX[v];
  endfunction

  function automatic logic [7:0] rc(input logic [NR_W-1:0] j);
    return {4'hF - j, j};
  endfunction

  function automatic logic [LANE_W-1:0] ror64(input logic [LANE_W-1:0] v, input int unsigned n);
    return (v >> n) | (v << (LANE_W - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round (constant add, S-box layer, linear layer); en=0 passes the state through.
module ascon_round
  import ascon_pkg::*;
(
  input  logic [STATE_W-1:0] i_state,
  input  logic [NR_W-1:0]    i_j,
  input  logic               i_en,
  output logic [STATE_W-1:0] o_state_c
);

  logic [LANE_W-1:0] w_x0, w_x1, w_x2, w_x3, w_x4;
  logic [LANE_W-1:0] w_s0, w_s1, w_s2, w_s3, w_s4;
  logic [4:0]        w_col;
  ascon_state_t      w_lin;

  always_comb begin
    w_x0  = i_state[X0_MSB:X0_LSB];
    w_x1  = i_state[X1_MSB:X1_LSB];
    w_x2  = i_state[X2_MSB:X2_LSB];
    w_x3  = i_state[X3_MSB:X3_LSB];
    w_x4  = i_state[X4_MSB:X4_LSB];
    w_s0  = '0;
    w_s1  = '0;
    w_s2  = '0;
    w_s3  = '0;
    w_s4  = '0;
    w_col = '0;
    w_lin = '0;

    w_x2[7:0] = w_x2[7:0] ^ rc(i_j);

    // Bit-sliced substitution, one 5-bit column per lane bit
    for (int i = 0; i < LANE_W; i++) begin
      w_col   = sbox({w_x0[i], w_x1[i], w_x2[i], w_x3[i], w_x4[i]});
      w_s0[i] = w_col[4];
      w_s1[i] = w_col[3];
      w_s2[i] = w_col[2];
      w_s3[i] = w_col[1];
      w_s4[i] = w_col[0];
    end

    w_lin.x0 = w_s0 ^ ror64(w_s0, ROT_X0_A) ^ ror64(w_s0, ROT_X0_B);
    w_lin.x1 = w_s1 ^ ror64(w_s1, ROT_X1_A) ^ ror64(w_s1, ROT_X1_B);
    w_lin.x2 = w_s2 ^ ror64(w_s2, ROT_X2_A) ^ ror64(w_s2, ROT_X2_B);
    w_lin.x3 = w_s3 ^ ror64(w_s3, ROT_X3_A) ^ ror64(w_s3, ROT_X3_B);
    w_lin.x4 = w_s4 ^ ror64(w_s4, ROT_X4_A) ^ ror64(w_s4, ROT_X4_B);

    o_state_c = i_en ? w_lin : i_state;
  end

endmodule

// File: rtl/ascon_perm_core.sv
// Ascon permutation p^R with runtime round count, UNROLL rounds per clock and start/done handshake.
module ascon_perm_core
  import ascon_pkg::*;
#(
  parameter int unsigned UNROLL     = 1,
  parameter int unsigned MAX_ROUNDS = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NR_W-1:0]    num_rounds,
  input  logic [STATE_W-1:0] state_in,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] state_out
);

  fsm_t               r_fsm;
  logic [STATE_W-1:0] r_state;
  logic [NR_W-1:0]    r_rcnt;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;

  logic [NR_W-1:0]    w_rsel;
  logic [IDX_W-1:0]   w_rsum;
  logic [NR_W-1:0]    w_rcnt_next;
  logic [STATE_W-1:0] w_next_state;

  // Round chain: stage g runs global round rcnt+g, bypassed once past the last round
  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    logic [IDX_W-1:0]   w_idx;
    logic               w_en;
    logic [NR_W-1:0]    w_j;
    logic [STATE_W-1:0] w_in;
    logic [STATE_W-1:0] w_out;

    if (g == 0) begin : g_first
      assign w_in = r_state;
    end else begin : g_next
      assign w_in = g_round[g-1].w_out;
    end

    assign w_idx = IDX_W'(r_rcnt) + IDX_W'(g);
    assign w_en  = (w_idx < IDX_W'(MAX_ROUNDS));
    assign w_j   = w_en ? w_idx[NR_W-1:0] : NR_W'(MAX_ROUNDS - 1);

    ascon_round u_round (
      .i_state   (w_in),
      .i_j       (w_j),
      .i_en      (w_en),
      .o_state_c (w_out)
    );
  end

  assign w_next_state = g_round[UNROLL-1].w_out;

  assign w_rsel      = (num_rounds > NR_W'(MAX_ROUNDS)) ? NR_W'(MAX_ROUNDS) : num_rounds;
  assign w_rsum      = IDX_W'(r_rcnt) + IDX_W'(UNROLL);
  assign w_rcnt_next = (w_rsum >= IDX_W'(MAX_ROUNDS)) ? NR_W'(MAX_ROUNDS) : w_rsum[NR_W-1:0];

  // Control FSM, round counter and state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= ST_IDLE;
      r_state <= '0;
      r_rcnt  <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        ST_IDLE: begin
          if (start) begin
            r_state <= state_in;
            r_rcnt  <= NR_W'(MAX_ROUNDS) - w_rsel;
            if (w_rsel == '0) begin
              r_done <= 1'b1;
            end else begin
              r_fsm   <= ST_RUN;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_state <= w_next_state;
          r_rcnt  <= w_rcnt_next;
          if (w_rcnt_next == NR_W'(MAX_ROUNDS)) begin
            r_fsm   <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign ready     = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign state_out = r_state;

endmodule

// File: tb/tb_ascon_perm_core.sv
// Bench for ascon_perm_core: six instances (UNROLL 1,2,3,4,6,12) checked against an independent Ascon model.
module tb_ascon_perm_core;

  localparam int NU = 6;
  localparam int UL [NU] = '{1, 2, 3, 4, 6, 12};
  localparam logic [7:0] RCT [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                      8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NU-1:0]  start_v = '0;
  logic [3:0]     num_rounds = '0;
  logic [319:0]   state_in = '0;
  logic [NU-1:0]  rdy_v, busy_v, done_v;
  logic [319:0]   sout [NU];

  int total = 0;
  int bad = 0;
  int mon_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    ascon_perm_core #(.UNROLL(UL[g]), .MAX_ROUNDS(12)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_v[g]),
      .num_rounds (num_rounds),
      .state_in   (state_in),
      .ready      (rdy_v[g]),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .state_out  (sout[g])
    );
  end

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    logic [127:0] w;
    w = {v, v} >> n;
    return w[63:0];
  endfunction

  // Reference permutation using the algebraic (chi-style) form of the S-box
  function automatic logic [319:0] model_perm(input logic [319:0] s, input int r);
    logic [63:0] a, b, c, d, e, t0, t1, t2, t3, t4;
    a = s[319:256]; b = s[255:192]; c = s[191:128]; d = s[127:64]; e = s[63:0];
    for (int j = 12 - r; j < 12; j++) begin
      c = c ^ {56'h0, RCT[j]};
      a = a ^ e; e = e ^ d; c = c ^ b;
      t0 = ~a & b; t1 = ~b & c; t2 = ~c & d; t3 = ~d & e; t4 = ~e & a;
      a = a ^ t1; b = b ^ t2; c = c ^ t3; d = d ^ t4; e = e ^ t0;
      b = b ^ a; a = a ^ e; d = d ^ c; c = ~c;
      a = a ^ rotr(a, 19) ^ rotr(a, 28);
      b = b ^ rotr(b, 61) ^ rotr(b, 39);
      c = c ^ rotr(c, 1)  ^ rotr(c, 6);
      d = d ^ rotr(d, 10) ^ rotr(d, 17);
      e = e ^ rotr(e, 7)  ^ rotr(e, 41);
    end
    return {a, b, c, d, e};
  endfunction

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Single call on instance u; caller is positioned #1 after a rising edge
  task automatic run_call(input int u, input logic [3:0] nr, input logic [319:0] st,
                          input int lat, input logic [319:0] exp, input string nm);
    int n;
    chk({nm, " ready_before"}, 320'(rdy_v[u]), 320'(1));
    num_rounds = nr;
    state_in   = st;
    start_v[u] = 1'b1;
    @(posedge clk); #1;
    start_v[u] = 1'b0;
    if (lat > 0) chk({nm, " busy"}, 320'(busy_v[u]), 320'(1));
    n = 0;
    while (!done_v[u] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 320'(n), 320'(lat));
    chk({nm, " state"}, sout[u], exp);
    @(posedge clk); #1;
    chk({nm, " done_drop"}, 320'(done_v[u]), 320'(0));
    chk({nm, " state_hold"}, sout[u], exp);
  endtask

  typedef struct {
    int           u;
    logic [3:0]   nr;
    int           lat;
    logic [319:0] exp;
  } vec_t;

  // Assertion-style monitor: busy==~ready, single-cycle done, state stable while idle
  logic [NU-1:0] p_done = '0, p_rdy = '0, p_start = '0;
  logic          p_rst = 1'b0;
  logic [319:0]  p_sout [NU];

  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      if (busy_v[u] !== ~rdy_v[u]) begin
        mon_err++;
        $display("FAIL busy_ready u=%0d: busy=%b ready=%b, required busy==~ready", u, busy_v[u], rdy_v[u]);
      end
      if (rst_n && p_done[u] && done_v[u]) begin
        mon_err++;
        $display("FAIL done_pulse u=%0d: done high two cycles, required one", u);
      end
      if (rst_n && p_rst && p_rdy[u] && rdy_v[u] && !p_start[u] && sout[u] !== p_sout[u]) begin
        mon_err++;
        $display("FAIL idle_stable u=%0d: state_out %h changed from %h while idle", u, sout[u], p_sout[u]);
      end
      p_sout[u] = sout[u];
    end
    p_done  = done_v;
    p_rdy   = rdy_v;
    p_start = start_v;
    p_rst   = rst_n;
  end

  logic [319:0] st0, st1, st_r;
  vec_t         vt [12];

  initial begin
    int n, r, seen;
    logic [NU-1:0] got;

    st0 = {64'h00001000808c0001, 64'hf23494a4b1f09f72, 64'h1120821ab7ef5039,
           64'h0288f6cd3f44a4c2, 64'h122103181031374d};
    st1 = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
           64'h8796a5b4c3d2e1f0, 64'hdeadbeefcafef00d};

    vt[0]  = '{u: 0, nr: 4'd12, lat: 12, exp: model_perm(st0, 12)};
    vt[1]  = '{u: 3, nr: 4'd6,  lat: 2,  exp: model_perm(st0, 6)};
    vt[2]  = '{u: 3, nr: 4'd8,  lat: 2,  exp: model_perm(st0, 8)};
    vt[3]  = '{u: 0, nr: 4'd0,  lat: 0,  exp: st0};
    vt[4]  = '{u: 5, nr: 4'd15, lat: 1,  exp: model_perm(st0, 12)};
    vt[5]  = '{u: 1, nr: 4'd12, lat: 6,  exp: model_perm(st0, 12)};
    vt[6]  = '{u: 2, nr: 4'd8,  lat: 3,  exp: model_perm(st0, 8)};
    vt[7]  = '{u: 4, nr: 4'd6,  lat: 1,  exp: model_perm(st0, 6)};
    vt[8]  = '{u: 5, nr: 4'd1,  lat: 1,  exp: model_perm(st0, 1)};
    vt[9]  = '{u: 2, nr: 4'd15, lat: 4,  exp: model_perm(st0, 12)};
    vt[10] = '{u: 1, nr: 4'd5,  lat: 3,  exp: model_perm(st0, 5)};
    vt[11] = '{u: 4, nr: 4'd0,  lat: 0,  exp: st0};

    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < NU; u++) begin
      chk($sformatf("reset_state u%0d", u), sout[u], 320'(0));
      chk($sformatf("reset_ready u%0d", u), 320'(rdy_v[u]), 320'(1));
      chk($sformatf("reset_done u%0d", u), 320'(done_v[u]), 320'(0));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      run_call(vt[i].u, vt[i].nr, st0, vt[i].lat, vt[i].exp, $sformatf("vec%0d", i));

    // start held high while busy: second state ignored until the done cycle accepts it
    num_rounds = 4'd12; state_in = st0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    num_rounds = 4'd8; state_in = st1;
    n = 0;
    while (!done_v[0] && n < 40) begin @(posedge clk); #1; n++; end
    chk("hold latency1", 320'(n), 320'(12));
    chk("hold state1", sout[0], model_perm(st0, 12));
    chk("hold ready_at_done", 320'(rdy_v[0]), 320'(1));
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    chk("b2b busy", 320'(busy_v[0]), 320'(1));
    n = 0;
    while (!done_v[0] && n < 40) begin @(posedge clk); #1; n++; end
    chk("b2b latency2", 320'(n), 320'(8));
    chk("b2b state2", sout[0], model_perm(st1, 8));
    @(posedge clk); #1;

    // Reset mid-run aborts without a done pulse
    num_rounds = 4'd12; state_in = st0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort state", sout[0], 320'(0));
    chk("abort ready", 320'(rdy_v[0]), 320'(1));
    chk("abort busy", 320'(busy_v[0]), 320'(0));
    chk("abort done", 320'(done_v[0]), 320'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done_v[0]) seen++;
    end
    chk("abort no_done", 320'(seen), 320'(0));
    run_call(0, 4'd12, st1, 12, model_perm(st1, 12), "after_abort");

    // Random states, all instances in parallel
    for (int it = 0; it < 1000; it++) begin
      for (int k = 0; k < 10; k++) st_r[k*32 +: 32] = $urandom;
      r = $urandom_range(12, 0);
      num_rounds = 4'(r);
      state_in = st_r;
      start_v = '1;
      @(posedge clk); #1;
      start_v = '0;
      got = '0;
      n = 0;
      while (got != '1 && n < 40) begin
        for (int u = 0; u < NU; u++) begin
          if (done_v[u] && !got[u]) begin
            got[u] = 1'b1;
            chk($sformatf("rnd%0d u%0d r%0d lat", it, u, r), 320'(n), 320'((r + UL[u] - 1) / UL[u]));
            chk($sformatf("rnd%0d u%0d r%0d state", it, u, r), sout[u], model_perm(st_r, r));
          end
        end
        if (got != '1) begin @(posedge clk); #1; n++; end
      end
      chk($sformatf("rnd%0d all_done", it), 320'(got), 320'({NU{1'b1}}));
      @(posedge clk); #1;
    end

    chk("monitor errors", 320'(mon_err), 320'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
